// File: rtl/inst_fetch.sv
// Instruction fetch stage: loadable instruction memory read at the PC address,
// registered into a fetch output with run/halt tracking, stall and flush.
module inst_fetch #(
  parameter int INST_WIDTH  = 9,
  parameter int ADDR_WIDTH  = 9,
  parameter int DEPTH       = 512,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_WIDTH-1:0]  prog_addr,
  input  logic [INST_WIDTH-1:0]  prog_data,
  input  logic [ADDR_WIDTH-1:0]  pc_addr,
  input  logic                   pc_halt,
  input  logic                   stall,
  input  logic                   flush,
  output logic [INST_WIDTH-1:0]  inst,
  output logic [ADDR_WIDTH-1:0]  inst_pc,
  output logic                   inst_valid,
  output logic                   fetch_busy,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [INST_WIDTH-1:0]   inst_reg;
  logic [ADDR_WIDTH-1:0]   inst_pc_reg;
  logic                    inst_valid_reg;
  logic                    fetch_busy_reg;
  logic                    halted_reg;
  logic [COUNT_WIDTH-1:0]  fetch_count_reg;

  logic [INST_WIDTH-1:0]   mem [DEPTH];
  logic                    prog_in_range;
  logic                    pc_in_range;
  logic                    load_ok;
  logic [INST_WIDTH-1:0]   rd_data;

  // Out-of-range addresses must not alias onto a low word through the index slice.
  assign prog_in_range = ({1'b0, prog_addr} < DEPTH_LIM);
  assign pc_in_range   = ({1'b0, pc_addr} < DEPTH_LIM);
  assign load_ok       = prog_we && prog_in_range && (state_reg != RUN);

  // Memory has no reset so program contents survive a reset of the fetch logic.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[prog_addr[IDX_W-1:0]] <= prog_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (pc_in_range) begin
      rd_data = mem[pc_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      inst_reg        <= '0;
      inst_pc_reg     <= '0;
      inst_valid_reg  <= 1'b0;
      fetch_busy_reg  <= 1'b0;
      halted_reg      <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg       <= RUN;
            fetch_busy_reg  <= 1'b1;
            halted_reg      <= 1'b0;
            fetch_count_reg <= '0;
          end
        end
        RUN: begin
          if (pc_halt) begin
            state_reg      <= HALTED;
            inst_valid_reg <= 1'b0;
            fetch_busy_reg <= 1'b0;
            halted_reg     <= 1'b1;
          end else if (flush) begin
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
          end else if (!stall) begin
            inst_reg       <= rd_data;
            inst_pc_reg    <= pc_addr;
            inst_valid_reg <= 1'b1;
            if (fetch_count_reg != '1) begin
              fetch_count_reg <= fetch_count_reg + 1'b1;
            end
          end
        end
        HALTED: begin
          if (start) begin
            state_reg       <= RUN;
            fetch_busy_reg  <= 1'b1;
            halted_reg      <= 1'b0;
            fetch_count_reg <= '0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          inst_valid_reg <= 1'b0;
          fetch_busy_reg <= 1'b0;
          halted_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign inst        = inst_reg;
  assign inst_pc     = inst_pc_reg;
  assign inst_valid  = inst_valid_reg;
  assign fetch_busy  = fetch_busy_reg;
  assign halted      = halted_reg;
  assign fetch_count = fetch_count_reg;

endmodule
